// File: rtl/temp_spi_poller.sv
// Round-robin poller for LM71-style 3-wire SPI sensors on a shared SC/SIO pair; optional TEMP_AVG_EN running mean.
// Latency: one 67 half-period frame per channel; temp_data updates one clk_50 cycle after the 16th read sample.
// Backpressure: none; enable low lets the current frame finish through CS_HOLD, then the poller idles.
module temp_spi_poller #(
    parameter int NUM_CH      = 2,
    parameter int CLK_DIV     = 25,
    parameter int POLL_CYCLES = 5000000,
    parameter int HYST        = 32
) (
    input  logic                 clk_50,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 shutdown,
    input  logic [13:0]          thresh,
    output logic [NUM_CH-1:0]    temp_cs_n,
    output logic                 temp_sc,
    inout  wire                  temp_sio,
    output logic [14*NUM_CH-1:0] temp_data,
    output logic [NUM_CH-1:0]    temp_valid,
    output logic [NUM_CH-1:0]    alarm,
    output logic [NUM_CH-1:0]    err,
    output logic                 busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PC_W  = $clog2(POLL_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT, CS_SETUP, READ, WRITE, CS_HOLD} state_t;

    state_t            state;
    logic [PC_W-1:0]   poll_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [6:0]        hp;
    logic [CH_W-1:0]   ch;
    logic [15:0]       sh;
    logic              rd_done;
    logic              wr_bit;
    logic              sio_oe;
    logic              sio_out;
    logic              tick;
    logic [13:0]       raw;
    logic [13:0]       new_temp;
    logic signed [14:0] t15, th15, lo15;
    logic              alarm_set, alarm_clr;

    assign temp_sio = sio_oe ? sio_out : 1'bz;
    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign busy     = (state != IDLE) && (state != WAIT);
    assign raw      = sh[15:2];

`ifdef TEMP_AVG_EN
    logic [13:0]        taps [NUM_CH][3];
    logic [NUM_CH-1:0]  seeded;
    logic signed [15:0] avg_sum;

    function automatic logic signed [15:0] sx16(input logic [13:0] v);
        return {{2{v[13]}}, v};
    endfunction

    always_comb begin
        avg_sum = sx16(raw) <<< 2;
        if (seeded[ch])
            avg_sum = sx16(raw) + sx16(taps[ch][0]) + sx16(taps[ch][1]) + sx16(taps[ch][2]);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            seeded <= '0;
            for (int i = 0; i < NUM_CH; i++)
                for (int j = 0; j < 3; j++)
                    taps[i][j] <= '0;
        end else if (rd_done) begin
            seeded[ch]  <= 1'b1;
            taps[ch][0] <= raw;
            taps[ch][1] <= seeded[ch] ? taps[ch][0] : raw;
            taps[ch][2] <= seeded[ch] ? taps[ch][1] : raw;
        end
    end

    assign new_temp = avg_sum[15:2];
`else
    assign new_temp = raw;
`endif

    // 15-bit compare so thresh - HYST cannot wrap near -8192
    assign t15       = {new_temp[13], new_temp};
    assign th15      = {thresh[13], thresh};
    assign lo15      = th15 - $signed(15'(HYST));
    assign alarm_set = (t15 >= th15);
    assign alarm_clr = (t15 < lo15);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            poll_cnt   <= '0;
            div_cnt    <= '0;
            hp         <= '0;
            ch         <= '0;
            sh         <= '0;
            rd_done    <= 1'b0;
            wr_bit     <= 1'b0;
            sio_oe     <= 1'b0;
            sio_out    <= 1'b0;
            temp_cs_n  <= '1;
            temp_sc    <= 1'b0;
            temp_data  <= '0;
            temp_valid <= '0;
            alarm      <= '0;
            err        <= '0;
        end else begin
            temp_valid <= '0;
            rd_done    <= 1'b0;
            if (rd_done) begin
                temp_data[ch*14 +: 14] <= new_temp;
                temp_valid[ch]         <= 1'b1;
                err[ch]                <= err[ch] | (sh[1:0] != 2'b11);
                if (alarm_set)
                    alarm[ch] <= 1'b1;
                else if (alarm_clr)
                    alarm[ch] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= WAIT;
                        poll_cnt <= PC_W'(1);
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state    <= IDLE;
                        poll_cnt <= '0;
                    end else if (poll_cnt >= PC_W'(POLL_CYCLES - 1)) begin
                        poll_cnt  <= '0;
                        state     <= CS_SETUP;
                        ch        <= '0;
                        temp_cs_n <= ~NUM_CH'(1);
                        wr_bit    <= shutdown;
                        div_cnt   <= '0;
                        hp        <= '0;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        hp      <= hp + 1'b1;
                        // hp counts half-periods: 0 setup, 1..64 SC activity, 65..66 hold
                        if (!hp[0] && hp <= 7'd62) begin
                            temp_sc <= 1'b1;
                            if (hp <= 7'd30)
                                sh <= {sh[14:0], temp_sio};
                            if (hp == 7'd30)
                                rd_done <= 1'b1;
                            if (hp == 7'd0)
                                state <= READ;
                        end else if (hp[0] && hp <= 7'd63) begin
                            temp_sc <= 1'b0;
                            if (hp >= 7'd31 && hp <= 7'd61) begin
                                sio_oe  <= 1'b1;
                                sio_out <= wr_bit;
                            end
                            if (hp == 7'd31)
                                state <= WRITE;
                            if (hp == 7'd63)
                                sio_oe <= 1'b0;
                        end else if (hp == 7'd64) begin
                            temp_cs_n <= '1;
                            state     <= CS_HOLD;
                        end else if (hp == 7'd66) begin
                            hp <= '0;
                            if (!enable) begin
                                state <= IDLE;
                                ch    <= '0;
                            end else if (ch == CH_W'(NUM_CH - 1)) begin
                                state    <= WAIT;
                                ch       <= '0;
                                poll_cnt <= '0;
                            end else begin
                                ch        <= ch + 1'b1;
                                temp_cs_n <= ~(NUM_CH'(1) << (ch + 1'b1));
                                wr_bit    <= shutdown;
                                state     <= CS_SETUP;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_temp_spi_poller.sv
// Directed bench for temp_spi_poller with a behavioural LM71 model on the shared SC/SIO pins.
module tb_temp_spi_poller;
    localparam int NUM_CH = 2, CLK_DIV = 4, POLL_CYCLES = 100, HYST = 32;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        shutdown = 1'b0;
    logic [13:0] thresh = 14'h0500;
    logic [1:0]  temp_cs_n;
    logic        temp_sc;
    wire         temp_sio;
    logic [27:0] temp_data;
    logic [1:0]  temp_valid, alarm, err;
    logic        busy;

    always #5 clk_50 = ~clk_50;

    temp_spi_poller #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES), .HYST(HYST)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .enable(enable), .shutdown(shutdown), .thresh(thresh),
        .temp_cs_n(temp_cs_n), .temp_sc(temp_sc), .temp_sio(temp_sio), .temp_data(temp_data),
        .temp_valid(temp_valid), .alarm(alarm), .err(err), .busy(busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    // sensor model: drives the read word after CS falls, shifts on SC falls, captures the write word
    logic [15:0] mdl_word [2];
    logic        mdl_oe = 1'b0;
    logic        mdl_bit = 1'b0;
    logic [15:0] mdl_sh = '0;
    logic [15:0] wr_sh = '0;
    logic [15:0] last_wr = '0;
    int          mdl_rise = 0, mdl_ch = 0, cyc = 0, t_rise1 = 0, t_rise2 = 0;
    int          frame_cnt = 0, last_ch = -1, last_rises = 0, last_period = 0;
    bit          active = 1'b0, prev_sc = 1'b0, overlap = 1'b0;
    int          valid_cnt [2] = '{0, 0};
    int          vrun [2] = '{0, 0};
    int          vmax = 0;

    assign temp_sio = mdl_oe ? mdl_bit : 1'bz;

    always @(posedge clk_50) cyc++;

    always @(negedge clk_50) begin
        if (reset_n && temp_cs_n == 2'b00) overlap = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (reset_n && temp_valid[c]) begin
                vrun[c]++;
                if (vrun[c] == 1) valid_cnt[c]++;
                if (vrun[c] > vmax) vmax = vrun[c];
            end else begin
                vrun[c] = 0;
            end
        end
        if (!reset_n || temp_cs_n == 2'b11) begin
            if (active && reset_n) begin
                frame_cnt++;
                last_ch     = mdl_ch;
                last_rises  = mdl_rise;
                last_wr     = wr_sh;
                last_period = t_rise2 - t_rise1;
            end
            active = 1'b0; mdl_oe = 1'b0; mdl_rise = 0; prev_sc = 1'b0;
        end else begin
            if (!active) begin
                active = 1'b1;
                mdl_ch = temp_cs_n[0] ? 1 : 0;
                mdl_sh = mdl_word[mdl_ch];
                mdl_oe = 1'b1;
                mdl_bit = mdl_sh[15];
                wr_sh = '0;
            end else if (temp_sc && !prev_sc) begin
                mdl_rise++;
                if (mdl_rise == 1) t_rise1 = cyc;
                if (mdl_rise == 2) t_rise2 = cyc;
                if (mdl_rise == 16) mdl_oe = 1'b0;
                if (mdl_rise > 16) wr_sh = {wr_sh[14:0], temp_sio};
            end else if (!temp_sc && prev_sc && mdl_rise < 16) begin
                mdl_sh = mdl_sh << 1;
                mdl_bit = mdl_sh[15];
            end
            prev_sc = temp_sc;
        end
    end

    task automatic wait_frame(input int ch);
        int start = frame_cnt;
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk_50); #1;
            if (frame_cnt != start && last_ch == ch) done = 1'b1;
            else if (frame_cnt != start) start = frame_cnt;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL wait_frame_ch%0d: no frame completed within 3000 cycles", ch);
        end
    endtask

    task automatic count_to_cs0(input string name);
        int n = 0;
        while (n < 1000) begin
            @(posedge clk_50); #1; n++;
            if (temp_cs_n[0] == 1'b0) break;
        end
        n_checks++;
        if (n !== 100) begin n_fail++; $display("FAIL %s: cs_n[0] fell after %0d clocks, want 100", name, n); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1;
        repeat (5) @(posedge clk_50); #1;
        n_checks++; if (temp_cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b want 11", temp_cs_n); end
        n_checks++; if (temp_sc !== 1'b0) begin n_fail++; $display("FAIL reset_sc: got %b want 0", temp_sc); end
        n_checks++; if (temp_data !== 28'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", temp_data); end
        n_checks++; if ({temp_valid, alarm, err, busy} !== 7'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {temp_valid, alarm, err, busy}); end
        @(negedge clk_50); reset_n = 1'b1;
        count_to_cs0("reset_release_wait");
        n_checks++; if (temp_cs_n !== 2'b10 || busy !== 1'b1) begin n_fail++; $display("FAIL first_frame_start: cs_n=%b busy=%b want 10/1", temp_cs_n, busy); end
    endtask

    task automatic test_read();
        wait_frame(0);
        n_checks++; if (last_rises !== 32) begin n_fail++; $display("FAIL read_rises: got %0d want 32", last_rises); end
        n_checks++; if (last_period !== 8) begin n_fail++; $display("FAIL sc_period: got %0d want 8", last_period); end
        n_checks++; if (temp_data[13:0] !== 14'h0320) begin n_fail++; $display("FAIL temp_ch0: got %h want 0320", temp_data[13:0]); end
        n_checks++; if (valid_cnt[0] !== 1) begin n_fail++; $display("FAIL valid_ch0_count: got %0d want 1", valid_cnt[0]); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL err_good: got %b want 00", err); end
        wait_frame(1);
        n_checks++; if (temp_data[27:14] !== 14'h3F60) begin n_fail++; $display("FAIL temp_ch1_neg: got %h want 3F60", temp_data[27:14]); end
        n_checks++; if (alarm !== 2'b00) begin n_fail++; $display("FAIL alarm_neg: got %b want 00", alarm); end
        n_checks++; if (valid_cnt[1] !== 1) begin n_fail++; $display("FAIL valid_ch1_count: got %0d want 1", valid_cnt[1]); end
        n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL cs_overlap: got %b want 0", overlap); end
    endtask

    task automatic test_alarm();
        logic [13:0] vals [3] = '{14'h0500, 14'h04F0, 14'h04DF};
        logic        exp_a [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            mdl_word[0] = {vals[i], 2'b11};
            wait_frame(0);
            n_checks++; if (temp_data[13:0] !== vals[i]) begin n_fail++; $display("FAIL alarm_temp_%0d: got %h want %h", i, temp_data[13:0], vals[i]); end
            n_checks++; if (alarm[0] !== exp_a[i]) begin n_fail++; $display("FAIL alarm_hyst_%0d: got %b want %b", i, alarm[0], exp_a[i]); end
        end
    endtask

    task automatic test_shutdown();
        bit seen = 1'b0;
        wait_frame(1);
        shutdown = 1'b1;
        mdl_word[1] = 16'h0C80;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk_50); #1;
            if (active && mdl_ch == 0 && mdl_rise >= 20) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL shutdown_frame_start: got %b want 1", seen); end
        shutdown = 1'b0;
        wait_frame(0);
        n_checks++; if (last_wr !== 16'hFFFF) begin n_fail++; $display("FAIL write_shutdown: got %h want FFFF", last_wr); end
        wait_frame(1);
        n_checks++; if (last_wr !== 16'h0000) begin n_fail++; $display("FAIL write_run: got %h want 0000", last_wr); end
        n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL err_set: got %b want 10", err); end
        n_checks++; if (temp_data[27:14] !== 14'h0320) begin n_fail++; $display("FAIL err_word_data: got %h want 0320", temp_data[27:14]); end
        mdl_word[1] = 16'h0C83;
        wait_frame(1);
        n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL err_sticky: got %b want 10", err); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int vc;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk_50); #1;
            if (active && mdl_rise == 5) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach: got %b want 1", seen); end
        vc = valid_cnt[0] + valid_cnt[1];
        reset_n = 1'b0; #1;
        n_checks++; if (temp_cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_mid_cs: got %b want 11", temp_cs_n); end
        n_checks++; if (temp_sc !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_sc_busy: got %b/%b want 0/0", temp_sc, busy); end
        repeat (50) @(posedge clk_50); #1;
        n_checks++; if (valid_cnt[0] + valid_cnt[1] !== vc) begin n_fail++; $display("FAIL reset_mid_valid: got %0d want %0d", valid_cnt[0] + valid_cnt[1], vc); end
        n_checks++; if (err !== 2'b00 || alarm !== 2'b00) begin n_fail++; $display("FAIL reset_mid_flags: err=%b alarm=%b want 00/00", err, alarm); end
        @(negedge clk_50); reset_n = 1'b1;
        count_to_cs0("reset_mid_wait");
    endtask

    task automatic test_enable_drop();
        int start = frame_cnt;
        int vc0 = valid_cnt[0];
        int n = 0;
        enable = 1'b0;
        while (n < 1000 && busy !== 1'b0) begin @(posedge clk_50); #1; n++; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_busy: got %b want 0", busy); end
        n_checks++; if (frame_cnt !== start + 1 || last_rises !== 32) begin n_fail++; $display("FAIL enable_drop_frame: frames=%0d rises=%0d want %0d/32", frame_cnt - start, last_rises, 1); end
        n_checks++; if (valid_cnt[0] !== vc0 + 1) begin n_fail++; $display("FAIL enable_drop_valid: got %0d want %0d", valid_cnt[0], vc0 + 1); end
        repeat (1000) @(posedge clk_50); #1;
        n_checks++; if (frame_cnt !== start + 1 || temp_cs_n !== 2'b11 || busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_idle: frames=%0d cs_n=%b busy=%b want 1/11/0", frame_cnt - start, temp_cs_n, busy); end
        n_checks++; if (vmax !== 1) begin n_fail++; $display("FAIL valid_width: got %0d want 1", vmax); end
        n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL cs_overlap_final: got %b want 0", overlap); end
    endtask

    initial begin
        mdl_word[0] = 16'h0C83;
        mdl_word[1] = 16'hFD83;
        test_reset();
        test_read();
        test_alarm();
        test_shutdown();
        test_reset_mid();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
